// File: rtl/alu_pkg.sv
// Shared opcode encodings and control FSM states for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles after start.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  always_comb begin
    acc_d = acc_q;
    if (b_q[0]) acc_d = acc_q + a_q;
  end

  // done flags the final step; product already includes that step's partial sum
  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle ops inline, mul via alu_mul_seq.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  state_e           state_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             ovf_q;
  logic             err_q;
  logic             out_valid_q;

  logic             accept_c;
  logic             is_mul_c;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic [SHW-1:0]   shamt_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_ovf_c;
  logic             alu_err_c;

  // Ready is suppressed during reset so no request slips in on the reset edge
  assign in_ready = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept_c = in_valid && in_ready;
  assign is_mul_c = (ALUControl == OP_MUL);

  assign sum_c   = in1 + in2;
  assign diff_c  = in1 - in2;
  assign shamt_c = in2[SHW-1:0];

  always_comb begin
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    alu_err_c = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        alu_res_c = sum_c;
        alu_ovf_c = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_c[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c = diff_c;
        alu_ovf_c = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff_c[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND:  alu_res_c = in1 & in2;
      OP_OR:   alu_res_c = in1 | in2;
      OP_NOR:  alu_res_c = ~(in1 | in2);
      OP_XOR:  alu_res_c = in1 ^ in2;
      OP_SLT:  alu_res_c = WIDTH'($signed(in1) < $signed(in2));
      OP_SLTU: alu_res_c = WIDTH'(in1 < in2);
      OP_SLL:  alu_res_c = in1 << shamt_c;
      OP_SRL:  alu_res_c = in1 >> shamt_c;
      OP_SRA:  alu_res_c = WIDTH'($signed(in1) >>> shamt_c);
      OP_MUL:  alu_res_c = '0;
      default: alu_err_c = 1'b1;
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept_c && is_mul_c),
    .a       (in1),
    .b       (in2),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM; an accept in DONE retires the held result on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept_c) begin
      if (is_mul_c) begin
        state_q     <= ST_BUSY;
        out_valid_q <= 1'b0;
      end else begin
        state_q     <= ST_DONE;
        out_valid_q <= 1'b1;
        res_q       <= alu_res_c;
        zero_q      <= (alu_res_c == '0);
        ovf_q       <= alu_ovf_c;
        err_q       <= alu_err_c;
      end
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_BUSY: begin
          if (mul_done) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            res_q       <= mul_product;
            zero_q      <= (mul_product == '0);
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc (WIDTH=32) against a plain-arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [3:0]  ALUControl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        zero;
  logic        ovf;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res        (res),
    .zero       (zero),
    .ovf        (ovf),
    .err        (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: true-precision arithmetic, overflow = result no longer representable
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic ov, output logic er);
    int          ia = a;
    int          ib = b;
    longint      sa = ia;
    longint      sb = ib;
    longint      s;
    logic [63:0] p;
    logic [4:0]  sh = b[4:0];
    r = '0; ov = 1'b0; er = 1'b0;
    case (op)
      4'b0010: begin s = sa + sb; r = s[31:0]; ov = (s != longint'(int'(r))); end
      4'b0110: begin s = sa - sb; r = s[31:0]; ov = (s != longint'(int'(r))); end
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0011: r = a ^ b;
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0100: r = (a < b) ? 32'd1 : 32'd0;
      4'b1000: r = a << sh;
      4'b1001: r = a >> sh;
      4'b1010: begin s = sa >>> sh; r = s[31:0]; end
      4'b1101: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      default: er = 1'b1;
    endcase
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One transaction from IDLE: accept, wait for result, hold it, then retire
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        eo;
    logic        ee;
    int          lat;
    int          exp_lat;
    bit          rdy_low;
    model(op, a, b, er, eo, ee);
    exp_lat = (op == 4'b1101) ? 33 : 1;
    @(negedge clk);
    in_valid = 1'b1; in1 = a; in2 = b; ALUControl = op; out_ready = 1'b0;
    #1 check("accept_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; in1 = $urandom; in2 = $urandom; ALUControl = 4'($urandom);
    lat = 1; rdy_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    if (exp_lat > 1) check("busy_in_ready_low", 64'(rdy_low), 64'd1);
    check("res", 64'(res), 64'(er));
    check("zero", 64'(zero), 64'(er == 32'd0));
    check("ovf", 64'(ovf), 64'(eo));
    check("err", 64'(err), 64'(ee));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold", {31'd0, out_valid, res}, {31'd0, 1'b1, er});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("retire", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  logic [3:0]  sc_ops [12] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'hC, 4'h3, 4'h7, 4'h4, 4'h8, 4'h9, 4'hA, 4'hF};
  logic [32:0] exp_q [$];

  initial begin
    logic [31:0] er;
    logic        eo;
    logic        ee;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] front;
    bit          seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; ALUControl = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_state", {59'd0, out_valid, zero, ovf, err, in_ready}, 64'd1);
    check("rst_res", 64'(res), 64'd0);

    // Directed corner cases
    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op(4'b0110, 32'h8000_0000, 32'h0000_0001, 0);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(4'b0100, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(4'b1010, 32'h8000_0000, 32'h0000_0004, 0);
    run_op(4'b1101, 32'h0001_0003, 32'h0000_0005, 2);
    run_op(4'b1111, 32'h0000_0123, 32'h0000_0456, 0);
    run_op(4'b0011, 32'h0000_0005, 32'h0000_0005, 0);

    // Back-to-back single-cycle ops: one result per cycle, in order
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op = sc_ops[$urandom_range(0, 11)]; a = rand_opnd(); b = rand_opnd();
      model(op, a, b, er, eo, ee);
      exp_q.push_back({ee, er});
      in_valid = 1'b1; in1 = a; in2 = b; ALUControl = op;
      #1 check("b2b_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      check("b2b_valid", 64'(out_valid), 64'd1);
      front = exp_q.pop_front();
      check("b2b_res", {31'd0, err, res}, {31'd0, front});
    end

    // Stall: result held while out_ready low, then retire + accept on one edge
    in_valid = 1'b1; in1 = 32'd10; in2 = 32'd20; ALUControl = 4'b0010;
    @(negedge clk);
    check("stall_first", {31'd0, out_valid, res}, {31'd0, 1'b1, 32'd30});
    out_ready = 1'b0; in1 = 32'd100; in2 = 32'd1; ALUControl = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("stall_res", {31'd0, out_valid, res}, {31'd0, 1'b1, 32'd30});
    end
    out_ready = 1'b1;
    #1 check("unstall_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("unstall_res", {31'd0, out_valid, res}, {31'd0, 1'b1, 32'd99});
    @(negedge clk);
    check("drain", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Reset in the middle of a multiply aborts it
    in_valid = 1'b1; in1 = 32'h1234_5678; in2 = 32'h0000_0777; ALUControl = 4'b1101;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1 check("rst_busy_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {31'd0, out_valid, res}, 64'd0);
    #1 check("abort_idle_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    run_op(4'b0010, 32'd2, 32'd3, 0);

    // Randomized ops over the full opcode space
    for (int i = 0; i < 50; i++) begin
      op = 4'($urandom);
      run_op(op, rand_opnd(), rand_opnd(), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal: 8..64, power of two).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width, derived, not overridden.
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  operation request valid.
REQ-006 Port in_ready  output  1  block can accept a request this cycle.
REQ-007 Port in1  input  WIDTH  operand A.
REQ-008 Port in2  input  WIDTH  operand B; low SHW bits give the shift amount.
REQ-009 Port ALUControl  input  4  opcode.
REQ-010 Port out_valid  output  1  result valid.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port res  output  WIDTH  result.
REQ-013 Port zero  output  1  res == 0.
REQ-014 Port ovf  output  1  signed overflow (add/sub only, else 0).
REQ-015 Port err  output  1  opcode undefined.

Function
REQ-016 Opcodes SHALL be: 0010 add, 0110 sub, 0000 and, 0001 or, 1100 nor, 0011 xor, 0111 slt (signed), 0100 sltu (unsigned), 1000 sll, 1001 srl, 1010 sra, 1101 mul (low WIDTH bits of product).
REQ-017 Any other opcode SHALL produce res=0, zero=1, ovf=0, err=1, with single-cycle latency.
REQ-018 Request accepted on an edge where in_valid && in_ready; operands and opcode captured at that edge, and later changes to the inputs are ignored.
REQ-019 FSM states: IDLE, BUSY, DONE; reset state IDLE.
REQ-020 IDLE: in_ready=1, out_valid=0; on accept, non-mul op -> DONE with result registered at that edge (latency 1); mul -> BUSY.
REQ-021 BUSY: shift-add multiply, one multiplier bit per cycle, exactly WIDTH cycles; in_ready=0; after the WIDTH-th BUSY edge -> DONE (out_valid first high WIDTH+1 cycles after accept).
REQ-022 DONE: out_valid=1; res/zero/ovf/err held stable until out_ready=1.
REQ-023 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready), combinationally.
REQ-024 DONE with out_ready && in_valid: result retired and new request accepted on the same edge; no bubble for single-cycle ops.
REQ-025 DONE with out_ready && !in_valid: -> IDLE.
REQ-026 slt/sltu res SHALL be zero-extended 1 or 0.
REQ-027 ovf for add: operand signs equal and result sign differs; for sub: operand signs differ and result sign differs from in1.
REQ-028 Shifts use in2[SHW-1:0] only; sra replicates in1 MSB.
REQ-029 Arithmetic wraps modulo 2^WIDTH; no saturation.

Reset
REQ-030 rst high at an edge SHALL force state IDLE, out_valid=0, res=0, zero=0, ovf=0, err=0, and clear multiplier accumulator/counter, overriding any other activity.
REQ-031 rst asserted mid-BUSY SHALL abort the multiply with no result ever presented.
REQ-032 During the rst cycle, in_ready SHALL be 0 and no request is accepted.

Structure
REQ-033 Package alu_pkg SHALL hold the 4-bit opcode constants and the FSM state enum; shared with the decoder.
REQ-034 Sub-module alu_mul_seq (start, a, b -> done, product; WIDTH-parameterised) SHALL implement the iterative multiply; all other ops are inline.

Verification (WIDTH=32)
REQ-035 add 0x7FFFFFFF+1 -> res 0x80000000, ovf=1, zero=0, out_valid 1 cycle after accept.
REQ-036 slt 0xFFFFFFFF,1 -> res 1; sltu same operands -> res 0; sra 0x80000000 by 4 -> 0xF8000000.
REQ-037 mul 0x00010003 * 0x00000005 -> res 0x0005000F, out_valid exactly 33 cycles after accept, in_ready=0 throughout BUSY.
REQ-038 Back-to-back ten single-cycle ops with out_ready=1 -> one result per cycle, in order; out_ready=0 for 3 cycles -> res stable and in_ready=0.
REQ-039 rst at BUSY cycle 10 of a mul -> next cycle IDLE, out_valid=0, res=0; following add 2+3 -> res 5.
REQ-040 opcode 1111 -> res 0, zero=1, err=1; next valid op clears err.
